// File: rtl/hc595_chain_driver.sv
// Serial driver for NUM_CH parallel 74HC595 daisy-chains: snapshots a zone vector,
// shifts CH_BITS bits into every chain at a programmable SHCP rate, then latches.
module hc595_chain_driver #(
    parameter int unsigned NUM_CH       = 6,
    parameter int unsigned CH_BITS      = 8,
    parameter int unsigned DIV          = 1,
    parameter bit          MSB_FIRST    = 1'b1,
    parameter bit          AUTO_REFRESH = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [NUM_CH*CH_BITS-1:0]  led_data,
    output logic                       busy,
    output logic                       frame_done,
    output logic                       shcp,
    output logic                       stcp,
    output logic                       oe_n,
    output logic [NUM_CH-1:0]          ds
);

    localparam int unsigned SNAP_W = NUM_CH * CH_BITS;
    localparam int unsigned IDX_W  = (CH_BITS > 1) ? $clog2(CH_BITS) : 1;
    localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CH_BITS - 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT_LO,
        ST_SHIFT_HI,
        ST_LATCH
    } state_e;

    state_e              state_q, state_d;
    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [SNAP_W-1:0]   snap_q, snap_d;
    logic [NUM_CH-1:0]   ds_q, ds_d;
    logic                shcp_q, shcp_d;
    logic                stcp_q, stcp_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                oe_n_q, oe_n_d;

    logic [SNAP_W-1:0]   snap_src;
    logic [IDX_W-1:0]    lo_idx;
    logic [IDX_W-1:0]    pos;
    logic [NUM_CH-1:0]   ds_sel;

    // Data for the next SHIFT_LO entry: the live vector during LOAD, else the snapshot.
    assign snap_src = (state_q == ST_LOAD) ? led_data : snap_q;
    assign lo_idx   = (state_q == ST_SHIFT_HI) ? idx_q + IDX_W'(1) : '0;
    assign pos      = MSB_FIRST ? IDX_LAST - lo_idx : lo_idx;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chain
        logic [CH_BITS-1:0] chain_word;
        assign chain_word = snap_src[c*CH_BITS +: CH_BITS];
        assign ds_sel[c]  = chain_word[pos];
    end

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        idx_d   = idx_q;
        snap_d  = snap_q;
        ds_d    = ds_q;
        shcp_d  = shcp_q;
        stcp_d  = stcp_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        oe_n_d  = oe_n_q;

        case (state_q)
            ST_IDLE: begin
                if (start || AUTO_REFRESH) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                snap_d  = led_data;
                idx_d   = '0;
                div_d   = '0;
                ds_d    = ds_sel;
                state_d = ST_SHIFT_LO;
            end
            ST_SHIFT_LO: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    shcp_d  = 1'b1;
                    state_d = ST_SHIFT_HI;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_SHIFT_HI: begin
                if (div_q == DIV_LAST) begin
                    div_d  = '0;
                    shcp_d = 1'b0;
                    if (idx_q == IDX_LAST) begin
                        stcp_d  = 1'b1;
                        state_d = ST_LATCH;
                    end else begin
                        idx_d   = lo_idx;
                        ds_d    = ds_sel;
                        state_d = ST_SHIFT_LO;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_LATCH: begin
                if (div_q == DIV_LAST) begin
                    div_d   = '0;
                    stcp_d  = 1'b0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    oe_n_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            div_q   <= '0;
            idx_q   <= '0;
            snap_q  <= '0;
            ds_q    <= '0;
            shcp_q  <= 1'b0;
            stcp_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            oe_n_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            idx_q   <= idx_d;
            snap_q  <= snap_d;
            ds_q    <= ds_d;
            shcp_q  <= shcp_d;
            stcp_q  <= stcp_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            oe_n_q  <= oe_n_d;
        end
    end

    assign busy       = busy_q;
    assign frame_done = done_q;
    assign shcp       = shcp_q;
    assign stcp       = stcp_q;
    assign oe_n       = oe_n_q;
    assign ds         = ds_q;

endmodule

// File: doc/hc595_chain_driver.md
Name: hc595_chain_driver

Overview:
Parametrised serial driver for NUM_CH parallel daisy-chains of 74HC595 shift registers that feed the local-dimming LED backlight zones. It snapshots a flat zone on/off vector at frame start and shifts CH_BITS bits into every chain simultaneously, with a programmable SHCP rate. It then pulses STCP and reports completion. It supports single-shot (start handshake) and free-running refresh modes, and it holds outputs blanked until the first full frame has been latched.

Parameters:
NUM_CH, 6, number of independent serial data lines (one ds bit per chain)
CH_BITS, 8, bits shifted per chain per frame (>=1, <=256)
DIV, 1, clk cycles per SHCP half-period and per STCP high time (>=1, <=255)
MSB_FIRST, 1, 1: chain bit CH_BITS-1 is sent first; 0: bit 0 is sent first
AUTO_REFRESH, 0, 1: restart a frame automatically after each frame_done; 0: frames only on start

Ports:
clk  input  1  system clock
rst  input  1  asynchronous reset, active-low
start  input  1  single-cycle frame request; sampled only in IDLE
led_data  input  NUM_CH*CH_BITS  zone vector; chain c uses led_data[c*CH_BITS +: CH_BITS]
busy  output  1  high from LOAD through end of LATCH
frame_done  output  1  one-cycle pulse after each STCP falling edge
shcp  output  1  shift clock to all chains
stcp  output  1  storage (latch) clock to all chains
oe_n  output  1  output enable to all chains, active-low
ds  output  NUM_CH  serial data, bit c drives chain c

Behaviour:
- Reset (async assert, sync release): state=IDLE; shcp=0, stcp=0, ds=0, busy=0, frame_done=0, oe_n=1. Internal counters and the snapshot are cleared. Asserting reset mid-frame aborts the frame immediately, and no partial stcp is issued.
- States: IDLE, LOAD, SHIFT_LO, SHIFT_HI, LATCH.
- IDLE: go to LOAD when start=1, or unconditionally when AUTO_REFRESH=1. start is ignored in all other states and is not queued.
- LOAD (1 cycle): capture led_data into the snapshot register, set busy=1, and clear the bit index. The snapshot is not affected by led_data changes for the rest of the frame.
- SHIFT_LO (DIV cycles): shcp=0. ds[c] = snapshot bit of chain c at the current bit index. That bit is position CH_BITS-1-idx when MSB_FIRST=1, and position idx otherwise. ds changes only on entry to SHIFT_LO, so data is stable for DIV cycles before the shcp rising edge.
- SHIFT_HI (DIV cycles): shcp=1 and ds is held. On exit, idx increments. If idx was CH_BITS-1, go to LATCH; otherwise go to SHIFT_LO.
- LATCH (DIV cycles): shcp=0, stcp=1, ds held. On exit:
  - stcp=0 and busy=0;
  - frame_done=1 for exactly one cycle;
  - oe_n=0 (sticky until reset);
  - return to IDLE.
- Frame length: 1 + 2*DIV*CH_BITS + DIV cycles from the LOAD cycle to the last LATCH cycle. frame_done is asserted in the following cycle.
- In AUTO_REFRESH, IDLE lasts exactly 1 cycle (the frame_done cycle), so frame period = frame length + 1.
- Counters: the divider counter is sized for DIV and the bit index counter for CH_BITS. No wrap beyond the terminal values. shcp, stcp, ds, busy, frame_done and oe_n are all registered outputs with no combinational path from inputs.

Test Plan:
1. Reset/blank (NUM_CH=2, CH_BITS=8, DIV=2, MSB_FIRST=1) -> after reset release, all outputs 0 except oe_n=1. A start pulse sets busy=1 one cycle later.
2. Data order -> led_data=16'hA55A, start. Chain 0 emits 0,1,0,1,1,0,1,0 and chain 1 emits 1,0,1,0,0,1,0,1 at the 8 shcp rising edges. There are 8 shcp pulses, each 2 cycles high. stcp is high for 2 cycles, frame_done follows at cycle 36 after start sampling, and oe_n goes low then.
3. MSB_FIRST=0 with the same data -> chain 0 emits 0,1,0,1,1,0,1,0 reversed (i.e. 0,1,0,1,1,0,1,0 read LSB-first = 0,1,0,1,1,0,1,0→bits 0..7 of 8'h5A: 0,1,0,1,1,0,1,0). A bench model comparison passes for both orders.
4. Snapshot and ignored start -> change led_data to 16'hFFFF and pulse start mid-frame. The current frame still shifts A55A, and no second frame starts after frame_done.
5. AUTO_REFRESH=1, DIV=1 -> frame_done pulses every 1+16+1+1 = 19 cycles continuously, and each new frame picks up the led_data value present at its LOAD cycle.
6. Reset mid-SHIFT_HI (bit 4) -> shcp, stcp and ds drop to 0 asynchronously and oe_n=1. After release, a clean frame runs with a full 8 bits.
